// File: rtl/piso_framer.sv
// Parallel-in/serial-out framer: start bit, LSB-first data, optional even parity, stop bit.
// The line idles high between frames and a STOP cycle can accept the next word with no gap.
module piso_framer #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic             par_q;
    logic [CW-1:0]    cnt_q;
    logic             so_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;

    assign load_ready = (state_q == IDLE) || (state_q == STOP);
    assign accept     = load_valid && load_ready;
    assign so         = so_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Outputs are registered alongside the state, so each reflects the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, STOP: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= START;
                        sreg_q  <= din;
                        par_q   <= ^din;
                        so_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        so_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    so_q    <= sreg_q[0];
                    sreg_q  <= sreg_q >> 1;
                end
                DATA: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        if (PARITY_EN) begin
                            state_q <= PARITY;
                            so_q    <= par_q;
                        end else begin
                            state_q <= STOP;
                            so_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        so_q   <= sreg_q[0];
                        sreg_q <= sreg_q >> 1;
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    so_q    <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    so_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_framer.sv
// Bench for piso_framer: directed frames plus random traffic against a frame-queue model.
module tb_piso_framer;
    localparam int W  = 4;
    localparam bit PE = 1'b1;

    typedef struct packed {
        logic so;
        logic busy;
        logic fd;
    } ln_t;
    localparam ln_t IDLE_LN = 3'b100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         load_valid = 1'b0;
    logic         load_ready, so, busy, frame_done;

    ln_t          exp_q[$];
    ln_t          cur = IDLE_LN;
    logic         accepted = 1'b0;
    logic [6:0]   hist = '0;
    int           n_chk = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    piso_framer #(.WIDTH(W), .PARITY_EN(PE)) dut (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(load_ready), .so(so), .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level for every cycle of one frame, straight from the frame format.
    function automatic void push_frame(input logic [W-1:0] w);
        exp_q.push_back(ln_t'(3'b010));
        for (int i = 0; i < W; i++) exp_q.push_back(ln_t'({w[i], 2'b10}));
        if (PE) exp_q.push_back(ln_t'({^w, 2'b10}));
        exp_q.push_back(ln_t'(3'b111));
    endfunction

    function automatic logic model_ready();
        return !cur.busy || cur.fd;
    endfunction

    task automatic check_line(input string pfx);
        chk({pfx, "_so"}, so, cur.so);
        chk({pfx, "_busy"}, busy, cur.busy);
        chk({pfx, "_frame_done"}, frame_done, cur.fd);
        chk({pfx, "_load_ready"}, load_ready, model_ready());
    endtask

    task automatic tick();
        @(posedge clk);
        accepted = load_valid && model_ready();
        if (accepted) push_frame(din);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else                  cur = IDLE_LN;
        @(negedge clk);
        hist = {hist[5:0], so};
        check_line("line");
    endtask

    task automatic pulse_frame(input logic [W-1:0] w);
        din = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int nb, fdmask, waits;

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_line("reset");
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_so", so, 1);

        // Single frame and parity-zero frame
        pulse_frame(4'b1011);
        chk("seq_1011", hist, 7'b0110111);
        tick();
        pulse_frame(4'b0110);
        chk("seq_0110", hist, 7'b0011001);
        tick();

        // Back-to-back frames
        nb = 0;
        fdmask = 0;
        din = 4'b1011;
        load_valid = 1'b1;
        tick();
        nb += int'(busy);
        din = 4'b0001;
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (accepted) load_valid = 1'b0;
            nb += int'(busy);
            if (frame_done) fdmask |= (1 << c);
        end
        chk("b2b_busy_cycles", nb, 14);
        chk("b2b_done_cycles", fdmask, (1 << 7) | (1 << 14));

        // Backpressure during DATA
        din = 4'b0001;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (2) tick();
        din = 4'b1111;
        load_valid = 1'b1;
        waits = 0;
        accepted = 1'b0;
        while (!accepted && waits < 20) begin
            tick();
            waits++;
        end
        chk("bp_accepted", accepted, 1);
        chk("bp_wait", waits, 5);
        load_valid = 1'b0;
        repeat (6) tick();
        chk("seq_bp_1111", hist, 7'b0111101);
        tick();

        // Reset in the middle of the third data bit
        din = 4'b1011;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        exp_q.delete();
        cur = IDLE_LN;
        #1;
        chk("rst_async_so", so, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_done", frame_done, 0);
        @(negedge clk);
        check_line("rst_hold");
        rst = 1'b0;
        pulse_frame(4'b0001);
        chk("seq_after_rst", hist, 7'b0100011);

        // Random traffic; upstream holds its word until it is accepted
        for (int i = 0; i < 400; i++) begin
            if (accepted || !load_valid) begin
                load_valid = ($urandom_range(0, 2) != 0);
                din = W'($urandom);
            end
            tick();
        end
        load_valid = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
